// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in / serial-out shift register.
// A WIDTH-bit word is captured on a load strobe and shifted out one bit per
// clock, either MSB first or LSB first. busy and serial_valid frame the stream.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the
// data bits. The port list is the same whether or not the macro is defined.
// Handshake: load has no ready. A load on any edge is always accepted, and it
// aborts any word still in flight. Each cycle with serial_valid=1 carries one
// bit on serial_out.
module piso_shifter #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);
`endif

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             data_bit;
    logic             next_bit;
    logic             active;

    // Shift register and remaining-bit counter; load wins over shifting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= parallel_in;
            cnt  <= LOAD_CNT;
        end else if (cnt != '0) begin
            if (MSB_FIRST != 0) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
            cnt <= cnt - CW'(1);
        end
    end

    assign data_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign active   = (cnt != '0);

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Even parity of the word, captured alongside it and sent last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^parallel_in;
        end
    end

    // The final counted cycle carries the parity bit instead of data.
    assign next_bit = (cnt == CW'(1)) ? parity_q : data_bit;
`else
    assign next_bit = data_bit;
`endif

    // The serial line is held low whenever no bit is being framed.
    assign serial_out   = active & next_bit;
    assign serial_valid = active;
    assign busy         = active;

endmodule

// File: tb/tb_piso_shifter.sv
// Self-checking bench for piso_shifter. It runs an MSB-first and an LSB-first
// instance side by side on shared stimulus. Expected bit streams are queued
// when a load is captured and compared cycle by cycle on the falling edge.
module tb_piso_shifter;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] parallel_in;

    logic so_m, sv_m, busy_m;
    logic so_l, sv_l, busy_l;

    logic [0:0] exp_m_q[$];
    logic [0:0] exp_l_q[$];
    logic [0:0] e_m, e_l;

    int n_checks = 0;
    int n_pass   = 0;

    piso_shifter #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .parallel_in  (parallel_in),
        .serial_out   (so_m),
        .serial_valid (sv_m),
        .busy         (busy_m)
    );

    piso_shifter #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .parallel_in  (parallel_in),
        .serial_out   (so_l),
        .serial_valid (sv_l),
        .busy         (busy_l)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A captured load discards whatever was still pending from the old word.
    task automatic push_word(input logic [WIDTH-1:0] w);
        exp_m_q.delete();
        exp_l_q.delete();
        for (int i = 0; i < WIDTH; i++) begin
            exp_m_q.push_back(w[WIDTH-1-i]);
            exp_l_q.push_back(w[i]);
        end
`ifdef PISO_PARITY_EN
        exp_m_q.push_back(^w);
        exp_l_q.push_back(^w);
`endif
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses load for one edge. Afterwards parallel_in is scrambled, which
    // must have no effect on the word being shifted out.
    task automatic load_word(input logic [WIDTH-1:0] w);
        load        = 1'b1;
        parallel_in = w;
        @(posedge clk);
        push_word(w);
        #1;
        load        = 1'b0;
        parallel_in = WIDTH'($urandom);
    endtask

    // Monitor: each falling edge either consumes one expected bit or expects idle.
    always @(negedge clk) begin
        if (exp_m_q.size() > 0) begin
            e_m = exp_m_q.pop_front();
            check("msb_bit", {31'd0, so_m}, {31'd0, e_m});
            check("msb_busy", {31'd0, busy_m}, 32'd1);
            check("msb_valid", {31'd0, sv_m}, 32'd1);
        end else begin
            check("msb_idle_bit", {31'd0, so_m}, 32'd0);
            check("msb_idle_busy", {31'd0, busy_m}, 32'd0);
            check("msb_idle_valid", {31'd0, sv_m}, 32'd0);
        end
        if (exp_l_q.size() > 0) begin
            e_l = exp_l_q.pop_front();
            check("lsb_bit", {31'd0, so_l}, {31'd0, e_l});
            check("lsb_busy", {31'd0, busy_l}, 32'd1);
            check("lsb_valid", {31'd0, sv_l}, 32'd1);
        end else begin
            check("lsb_idle_bit", {31'd0, so_l}, 32'd0);
            check("lsb_idle_busy", {31'd0, busy_l}, 32'd0);
            check("lsb_idle_valid", {31'd0, sv_l}, 32'd0);
        end
    end

    // Watchdog bounds the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        int               gap;

        // Reset, then idle.
        reset       = 1'b0;
        load        = 1'b0;
        parallel_in = '0;
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        wait_cycles(3);

        // Basic word 1101 on both bit orders.
        load_word(4'b1101);
        wait_cycles(NBITS + 1);

        // Parity build: a word with even parity 0.
        load_word(4'b1001);
        wait_cycles(NBITS + 1);

        // Reload mid-word after two bits.
        load_word(4'b1111);
        wait_cycles(1);
        load_word(4'b0001);
        wait_cycles(NBITS + 1);

        // Back-to-back: new load on the edge that consumes the last bit.
        load_word(4'b1010);
        wait_cycles(NBITS - 1);
        load_word(4'b0110);
        wait_cycles(NBITS + 1);

        // Load held high: the word reloads each edge and the first bit repeats.
        load        = 1'b1;
        parallel_in = 4'b1010;
        repeat (4) begin
            @(posedge clk);
            push_word(4'b1010);
        end
        #1;
        load = 1'b0;
        wait_cycles(NBITS + 1);

        // Asynchronous reset mid-word: outputs clear without waiting for an edge.
        load_word(4'b1011);
        wait_cycles(1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_msb_bit", {31'd0, so_m}, 32'd0);
        check("rst_async_msb_busy", {31'd0, busy_m}, 32'd0);
        check("rst_async_lsb_bit", {31'd0, so_l}, 32'd0);
        check("rst_async_lsb_valid", {31'd0, sv_l}, 32'd0);
        exp_m_q.delete();
        exp_l_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        wait_cycles(NBITS + 1);

        // Random words with random gaps (gap 0 reloads after a single bit).
        for (int i = 0; i < 24; i++) begin
            w   = WIDTH'($urandom);
            gap = $urandom_range(0, NBITS + 1);
            load_word(w);
            wait_cycles(gap);
        end
        wait_cycles(NBITS + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
